// File: rtl/next_block_queue_if.sv
// Signal bundle between the next-block queue, the free-running block generator and the game FSM.
// Field-width macros fall back to the standard playfield sizes when the project headers are absent.
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif

interface next_block_queue_if #(
  parameter int DEPTH = 2
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                 flush_i;
  logic                                 gen_en_o;
  logic        [63:0]                   gen_data_i;
  logic        [`TETRIS_COLORS_WIDTH-1:0] gen_color_i;
  logic        [1:0]                    gen_rotation_i;
  logic signed [`FIELD_COL_CNT_WIDTH:0] gen_x_i;
  logic signed [`FIELD_ROW_CNT_WIDTH:0] gen_y_i;
  logic                                 block_valid_o;
  logic                                 block_pop_i;
  logic        [63:0]                   block_data_o;
  logic        [`TETRIS_COLORS_WIDTH-1:0] block_color_o;
  logic        [1:0]                    block_rotation_o;
  logic signed [`FIELD_COL_CNT_WIDTH:0] block_x_o;
  logic signed [`FIELD_ROW_CNT_WIDTH:0] block_y_o;
  logic        [CNT_W-1:0]              count_o;

  // master: the queue itself; slave: generator plus game FSM side
  modport master (
    input  flush_i, gen_data_i, gen_color_i, gen_rotation_i, gen_x_i, gen_y_i, block_pop_i,
    output gen_en_o, block_valid_o, block_data_o, block_color_o, block_rotation_o,
           block_x_o, block_y_o, count_o
  );

  modport slave (
    output flush_i, gen_data_i, gen_color_i, gen_rotation_i, gen_x_i, gen_y_i, block_pop_i,
    input  gen_en_o, block_valid_o, block_data_o, block_color_o, block_rotation_o,
           block_x_o, block_y_o, count_o
  );
endinterface

// File: rtl/next_block_queue.sv
// Prefetch FIFO between the block generator and the game FSM, hiding the generator pipeline latency.
// Optional macro NEXT_BLOCK_NO_REPEAT_EN: reroll once when a captured color repeats the previous one.
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif

module next_block_queue #(
  parameter int DEPTH         = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  next_block_queue_if.master q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW    = `TETRIS_COLORS_WIDTH;
  localparam int XW    = `FIELD_COL_CNT_WIDTH + 1;
  localparam int YW    = `FIELD_ROW_CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SET_W-1:0]      r_settle;
  logic [SET_W-1:0]      w_settle_nxt;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_gen_en;

  logic        [63:0]    r_data [DEPTH];
  logic        [CW-1:0]  r_color[DEPTH];
  logic        [1:0]     r_rot  [DEPTH];
  logic signed [XW-1:0]  r_x    [DEPTH];
  logic signed [YW-1:0]  r_y    [DEPTH];

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_reject;
  logic                  w_write;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_valid   = (r_count != '0);
  assign w_pop     = q.block_pop_i && w_valid && !q.flush_i;
  assign w_capture = (r_state == S_CAPTURE) && !q.flush_i;
  assign w_write   = w_capture && !w_reject;

`ifdef NEXT_BLOCK_NO_REPEAT_EN
  logic [CW-1:0] r_last_color;
  logic          r_reroll;

  assign w_reject = (q.gen_color_i == r_last_color) && !r_reroll;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_color <= '0;
      r_reroll     <= 1'b0;
    end else if (q.flush_i) begin
      r_last_color <= '0;
      r_reroll     <= 1'b0;
    end else if (w_capture) begin
      if (w_reject) begin
        r_reroll <= 1'b1;
      end else begin
        r_last_color <= q.gen_color_i;
        r_reroll     <= 1'b0;
      end
    end
  end
`else
  assign w_reject = 1'b0;
`endif

  // A slot is reserved at IDLE, so every later CAPTURE has room even if pops arrive meanwhile.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    if (q.flush_i) begin
      w_state_nxt  = S_IDLE;
      w_settle_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count < CNT_W'(DEPTH)) || w_pop) w_state_nxt = S_KICK;
        end
        S_KICK: begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = SET_W'(SETTLE_CYCLES - 1);
        end
        S_SETTLE: begin
          if (r_settle <= SET_W'(1)) begin
            w_state_nxt  = S_CAPTURE;
            w_settle_nxt = '0;
          end else begin
            w_settle_nxt = r_settle - 1'b1;
          end
        end
        S_CAPTURE: begin
          w_state_nxt = w_reject ? S_KICK : S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_gen_en <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_gen_en <= (w_state_nxt == S_KICK);
      if (q.flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_write) r_wptr <= ptr_inc(r_wptr);
        if (w_pop)   r_rptr <= ptr_inc(r_rptr);
        case ({w_write, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage carries no reset; the head mux below hides stale entries.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_data [r_wptr] <= q.gen_data_i;
      r_color[r_wptr] <= q.gen_color_i;
      r_rot  [r_wptr] <= q.gen_rotation_i;
      r_x    [r_wptr] <= q.gen_x_i;
      r_y    [r_wptr] <= q.gen_y_i;
    end
  end

  assign q.gen_en_o         = r_gen_en;
  assign q.count_o          = r_count;
  assign q.block_valid_o    = w_valid;
  assign q.block_data_o     = w_valid ? r_data [r_rptr] : '0;
  assign q.block_color_o    = w_valid ? r_color[r_rptr] : '0;
  assign q.block_rotation_o = w_valid ? r_rot  [r_rptr] : '0;
  assign q.block_x_o        = w_valid ? r_x    [r_rptr] : '0;
  assign q.block_y_o        = w_valid ? r_y    [r_rptr] : '0;

endmodule

// File: tb/tb_next_block_queue.sv
// Bench for next_block_queue: generator model with a 2-register pipeline, queue-based reference model,
// directed scenarios with literal expectations, then a randomized pop/flush/reset soak.
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif

module tb_next_block_queue;
  localparam int DEPTH  = 2;
  localparam int SETTLE = 3;
  localparam int CW     = `TETRIS_COLORS_WIDTH;
  localparam int XW     = `FIELD_COL_CNT_WIDTH + 1;
  localparam int YW     = `FIELD_ROW_CNT_WIDTH + 1;

  typedef struct packed {
    logic        [63:0]   data;
    logic        [CW-1:0] color;
    logic        [1:0]    rot;
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
  } blk_t;
  localparam int BW = $bits(blk_t);

  logic clk   = 1'b0;
  logic rst_i = 1'b1;

  next_block_queue_if #(.DEPTH(DEPTH)) bus ();

  next_block_queue #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .q     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Generator: the first register loads on the enable pulse, the second follows every cycle.
  blk_t        p1 = '0;
  blk_t        p2 = '0;
  blk_t        gen_next = '0;
  int unsigned color_plan[$];
  int          color_max = 7;

  always @(posedge clk) begin
    if (bus.gen_en_o) p1 <= gen_next;
    p2 <= p1;
  end

  assign bus.gen_data_i     = p2.data;
  assign bus.gen_color_i    = p2.color;
  assign bus.gen_rotation_i = p2.rot;
  assign bus.gen_x_i        = p2.x;
  assign bus.gen_y_i        = p2.y;

  function automatic blk_t new_block();
    blk_t b;
    b.data = {$urandom, $urandom};
    b.rot  = 2'($urandom);
    b.x    = XW'($urandom);
    b.y    = YW'($urandom);
    if (color_plan.size() > 0) b.color = CW'(color_plan.pop_front());
    else                       b.color = CW'($urandom_range(1, color_max));
    return b;
  endfunction

  logic pop_seen   = 1'b0;
  logic flush_seen = 1'b0;
  always @(posedge clk) begin
    pop_seen   <= bus.block_pop_i;
    flush_seen <= bus.flush_i;
  end

  int cyc;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference model state
  blk_t          fifo[$];
  blk_t          pend_blk[$];
  int            pend_due[$];
  int            idle_run = 0;
  logic [CW-1:0] m_last = '0;
  bit            m_reroll = 1'b0;
  bit            hist_en = 1'b0;
  bit            gen_hist[16];
  int            cnt_hist[16];

  always @(negedge clk) begin
    blk_t b;
    blk_t exp_head;
    blk_t dut_head;
    dut_head = {bus.block_data_o, bus.block_color_o, bus.block_rotation_o,
                bus.block_x_o, bus.block_y_o};
    if (rst_i) begin
      fifo.delete();
      pend_blk.delete();
      pend_due.delete();
      idle_run = 0;
      m_last   = '0;
      m_reroll = 1'b0;
      chk("rst_count", BW'(bus.count_o), BW'(0));
      chk("rst_valid", BW'(bus.block_valid_o), BW'(0));
      chk("rst_gen_en", BW'(bus.gen_en_o), BW'(0));
      chk("rst_head", dut_head, BW'(0));
    end else begin
      if (flush_seen) begin
        fifo.delete();
        pend_blk.delete();
        pend_due.delete();
        m_last   = '0;
        m_reroll = 1'b0;
      end else begin
        if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
          b = pend_blk.pop_front();
          void'(pend_due.pop_front());
`ifdef NEXT_BLOCK_NO_REPEAT_EN
          if (b.color == m_last && !m_reroll) begin
            m_reroll = 1'b1;
          end else begin
            fifo.push_back(b);
            m_last   = b.color;
            m_reroll = 1'b0;
          end
`else
          fifo.push_back(b);
`endif
        end
      end

      exp_head = (fifo.size() > 0) ? fifo[0] : '0;
      chk("count", BW'(bus.count_o), BW'(fifo.size()));
      chk("valid", BW'(bus.block_valid_o), BW'(fifo.size() > 0));
      chk("head", dut_head, exp_head);

      if (bus.gen_en_o) begin
        chk("kick_reserved", BW'(pend_due.size() == 0 && fifo.size() < DEPTH), BW'(1));
        gen_next = new_block();
        pend_blk.push_back(gen_next);
        pend_due.push_back(cyc + SETTLE + 1);
        idle_run = 0;
      end else if (flush_seen) begin
        idle_run = 0;
      end else if (pend_due.size() == 0 && fifo.size() < DEPTH) begin
        idle_run++;
        chk("refill_gap", BW'(idle_run <= 1), BW'(1));
      end else begin
        idle_run = 0;
      end

      if (hist_en && cyc < 16) begin
        gen_hist[cyc] = bus.gen_en_o;
        cnt_hist[cyc] = int'(bus.count_o);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_count(input int n, input string name);
    int t = 0;
    while (int'(bus.count_o) != n && t < 200) begin
      step();
      t++;
    end
    chk(name, BW'(bus.count_o), BW'(n));
  endtask

  task automatic wait_gen_en(input string name);
    int t = 0;
    while (!bus.gen_en_o && t < 50) begin
      step();
      t++;
    end
    chk(name, BW'(bus.gen_en_o), BW'(1));
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
  endtask

  initial begin
    int pulses;
    int sum;
    bus.flush_i     = 1'b0;
    bus.block_pop_i = 1'b0;
    hist_en         = 1'b1;
    color_plan.push_back(1);
    color_plan.push_back(2);
    repeat (3) step();
    #2 rst_i = 1'b0;

    // Reset release: pulses at 1 and 6, count 1 at 5, 2 at 10, nothing further while full
    repeat (14) step();
    hist_en = 1'b0;
    sum = 0;
    for (int i = 1; i < 14; i++) sum += int'(gen_hist[i]);
    chk("kick_c1", BW'(gen_hist[1]), BW'(1));
    chk("kick_c6", BW'(gen_hist[6]), BW'(1));
    chk("kick_total", BW'(sum), BW'(2));
    chk("cnt_c4", BW'(cnt_hist[4]), BW'(0));
    chk("cnt_c5", BW'(cnt_hist[5]), BW'(1));
    chk("cnt_c9", BW'(cnt_hist[9]), BW'(1));
    chk("cnt_c10", BW'(cnt_hist[10]), BW'(2));
    chk("cnt_c13", BW'(cnt_hist[13]), BW'(2));

    // Full queue 3,5 then a single pop; next refill carries color 2
    do_flush();
    chk("flush_cnt", BW'(bus.count_o), BW'(0));
    color_plan.push_back(3);
    color_plan.push_back(5);
    color_plan.push_back(2);
    wait_count(2, "fill_35");
    chk("head_3", BW'(bus.block_color_o), BW'(3));
    bus.block_pop_i = 1'b1;
    step();
    bus.block_pop_i = 1'b0;
    chk("pop_head_5", BW'(bus.block_color_o), BW'(5));
    chk("pop_cnt_1", BW'(bus.count_o), BW'(1));
    chk("pop_kick", BW'(bus.gen_en_o), BW'(1));

    // Pop on the CAPTURE cycle of color 2 with count 1
    repeat (3) step();
    bus.block_pop_i = 1'b1;
    step();
    bus.block_pop_i = 1'b0;
    chk("cap_pop_cnt", BW'(bus.count_o), BW'(1));
    chk("cap_pop_head", BW'(bus.block_color_o), BW'(2));

    // Pop while empty
    do_flush();
    chk("empty_cnt0", BW'(bus.count_o), BW'(0));
    bus.block_pop_i = 1'b1;
    step();
    bus.block_pop_i = 1'b0;
    chk("empty_pop_cnt", BW'(bus.count_o), BW'(0));
    chk("empty_pop_valid", BW'(bus.block_valid_o), BW'(0));
    chk("empty_pop_head", {bus.block_data_o, bus.block_color_o, bus.block_rotation_o,
                           bus.block_x_o, bus.block_y_o}, BW'(0));

    // Flush during SETTLE with one entry stored
    wait_count(1, "settle_cnt1");
    wait_gen_en("settle_kick");
    step();
    do_flush();
    chk("settle_flush_cnt", BW'(bus.count_o), BW'(0));
    chk("settle_flush_valid", BW'(bus.block_valid_o), BW'(0));
    step();
    chk("settle_restart", BW'(bus.gen_en_o), BW'(1));

    // Generator returns 4,4,4
    do_flush();
    color_plan.push_back(4);
    color_plan.push_back(4);
    color_plan.push_back(4);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.gen_en_o) pulses++;
    end
`ifdef NEXT_BLOCK_NO_REPEAT_EN
    chk("rep_pulses", BW'(pulses), BW'(3));
`else
    chk("rep_pulses", BW'(pulses), BW'(2));
`endif
    chk("rep_cnt", BW'(bus.count_o), BW'(2));
    chk("rep_head0", BW'(bus.block_color_o), BW'(4));
    bus.block_pop_i = 1'b1;
    step();
    bus.block_pop_i = 1'b0;
    chk("rep_head1", BW'(bus.block_color_o), BW'(4));

    // Randomized soak with narrow color range, occasional flush and one mid-run reset
    color_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        bus.block_pop_i = 1'b0;
        bus.flush_i     = 1'b0;
        #2 rst_i = 1'b1;
        step();
        step();
        #2 rst_i = 1'b0;
        step();
      end
      bus.block_pop_i = ($urandom_range(0, 99) < 35);
      bus.flush_i     = ($urandom_range(0, 99) < 2);
      step();
    end
    bus.block_pop_i = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
